simmem_drain_ctrl: RTL
======================

// Module: simmem_drain_ctrl
// PURPOSE
// - Sequences fpga_simmem_en_i of simmem_top: enables acceptance of new requests, and on disable
//   drains all in-flight write/read transactions before reporting quiescence.
// - Tracks outstanding AW and AR bursts from the handshakes seen at the simmem_top boundary.
// - Flags a drain timeout and counter over/underflow.
// PARAMETERS
// - MaxOutstW     8     width of each outstanding-burst counter; saturates at 2**MaxOutstW-1
// - DrainTimeout  1024  consecutive DRAIN cycles with no completion before TIMEOUT
// - TimeoutW      11    timer width; must satisfy 2**TimeoutW > DrainTimeout
// PORTS
// - clk_i          in   1          clock
// - rst_i          in   1          asynchronous active-high reset
// - en_req_i       in   1          level request to run the simulated memory
// - clr_i          in   1          sync clear: counters, errors, timer to 0; state -> OFF
// - waddr_hs_i     in   1          waddr_in_valid & waddr_in_ready (AW burst accepted)
// - raddr_hs_i     in   1          raddr_in_valid & raddr_in_ready (AR burst accepted)
// - wrsp_hs_i      in   1          wrsp_out_valid & wrsp_out_ready (B response delivered)
// - rdata_hs_i     in   1          rdata_out_valid & rdata_out_ready (R beat delivered)
// - rdata_last_i   in   1          last flag of the R beat in rdata_hs_i
// - en_o           out  1          drives fpga_simmem_en_i of simmem_top (registered)
// - state_o        out  2          0 OFF, 1 ON, 2 DRAIN, 3 TIMEOUT
// - w_outst_o      out  MaxOutstW  outstanding write bursts
// - r_outst_o      out  MaxOutstW  outstanding read bursts
// - drained_o      out  1          one-cycle pulse on DRAIN -> OFF
// - timeout_o      out  1          sticky; set on entry to TIMEOUT
// - err_o          out  1          sticky; set on counter overflow or underflow
// BEHAVIOUR
// - Reset: state OFF; en_o, drained_o, timeout_o, err_o = 0; counters and timer = 0.
// - All outputs are registered. en_o = (state == ON) and changes in the cycle after the transition.
// - OFF: go to ON when en_req_i=1 and both counters are 0. Otherwise remain in OFF.
// - ON: go to DRAIN when en_req_i=0.
// - DRAIN: go to OFF when both next-counter values are 0. drained_o pulses in that cycle.
//   * en_req_i is ignored in DRAIN; there is no direct DRAIN -> ON transition.
//   * Timer increments each DRAIN cycle with no completion. It clears on any completion
//     or on DRAIN entry.
//   * Timer reaching DrainTimeout -> TIMEOUT.
// - TIMEOUT: en_o=0 and timeout_o=1. Exit only via clr_i or reset.
// - clr_i overrides everything for one cycle.
// - Counting is active in every state, so late handshakes are still tracked.
// - w counter: +1 on waddr_hs_i, -1 on wrsp_hs_i. Both in the same cycle: unchanged.
// - r counter: +1 on raddr_hs_i, -1 on rdata_hs_i & rdata_last_i. Non-last beats are ignored.
// - Completion for the timer is wrsp_hs_i | (rdata_hs_i & rdata_last_i).
// - Overflow (inc at max, no dec): counter holds max, err_o set.
// - Underflow (dec at 0, no inc): counter holds 0, err_o set.
// - Asynchronous reset mid-drain immediately returns to the reset values. No drained_o pulse.
// TESTING
// - Reset asserted in DRAIN with w_outst=2 -> state_o=0, en_o=0, counters 0, drained_o never pulses.
// - en_req=1 -> en_o=1 two cycles later. 3 AW and 2 AR handshakes give w=3, r=2.
//   Deassert en_req, then deliver 3 B and 2 last R -> drained_o pulses once, state_o=0.
// - waddr_hs_i and wrsp_hs_i in the same cycle with w=1 -> w stays 1.
//   rdata_hs_i with last=0 -> r unchanged.
// - DrainTimeout=16, DRAIN with w=1 and no responses -> state_o=3 after 16 cycles, timeout_o=1.
//   clr_i -> state_o=0, w=0, timeout_o=0.
// - In OFF, wrsp_hs_i with w=0 -> err_o=1, w=0. en_req=1 still allows ON.
// - MaxOutstW=2: 4 AW handshakes -> w saturates at 3 and err_o=1.

Source files
------------

// File: rtl/simmem_drain_ctrl.sv
// Enable/drain sequencer for simmem_top: counts outstanding AW/AR bursts, drains them on
// disable, and flags drain timeouts and counter over/underflow.
module simmem_drain_ctrl #(
    parameter int unsigned MaxOutstW    = 8,
    parameter int unsigned DrainTimeout = 1024,
    parameter int unsigned TimeoutW     = 11
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_req_i,
    input  logic                 clr_i,
    input  logic                 waddr_hs_i,
    input  logic                 raddr_hs_i,
    input  logic                 wrsp_hs_i,
    input  logic                 rdata_hs_i,
    input  logic                 rdata_last_i,
    output logic                 en_o,
    output logic [1:0]           state_o,
    output logic [MaxOutstW-1:0] w_outst_o,
    output logic [MaxOutstW-1:0] r_outst_o,
    output logic                 drained_o,
    output logic                 timeout_o,
    output logic                 err_o
);

    typedef enum logic [1:0] {
        StOff     = 2'd0,
        StOn      = 2'd1,
        StDrain   = 2'd2,
        StTimeout = 2'd3
    } state_e;

    localparam logic [MaxOutstW-1:0] CntMax     = '1;
    localparam logic [MaxOutstW-1:0] CntOne     = MaxOutstW'(1);
    localparam logic [TimeoutW-1:0]  TimerOne   = TimeoutW'(1);
    localparam logic [TimeoutW-1:0]  TimeoutLim = TimeoutW'(DrainTimeout);

    state_e               state_q;
    logic                 en_q;
    logic                 drained_q;
    logic                 timeout_q;
    logic                 err_q;
    logic [MaxOutstW-1:0] w_q, w_d;
    logic [MaxOutstW-1:0] r_q, r_d;
    logic [TimeoutW-1:0]  timer_q;
    logic [TimeoutW-1:0]  timer_inc;
    logic                 w_inc, w_dec, r_inc, r_dec;
    logic                 w_err, r_err;
    logic                 compl;

    // Saturating up/down counters; simultaneous inc and dec cancel out.
    always_comb begin
        w_inc = waddr_hs_i;
        w_dec = wrsp_hs_i;
        r_inc = raddr_hs_i;
        r_dec = rdata_hs_i & rdata_last_i;
        compl = w_dec | r_dec;

        w_d   = w_q;
        w_err = 1'b0;
        if (w_inc && !w_dec) begin
            if (w_q == CntMax) w_err = 1'b1;
            else               w_d   = w_q + CntOne;
        end else if (w_dec && !w_inc) begin
            if (w_q == '0) w_err = 1'b1;
            else           w_d   = w_q - CntOne;
        end

        r_d   = r_q;
        r_err = 1'b0;
        if (r_inc && !r_dec) begin
            if (r_q == CntMax) r_err = 1'b1;
            else               r_d   = r_q + CntOne;
        end else if (r_dec && !r_inc) begin
            if (r_q == '0) r_err = 1'b1;
            else           r_d   = r_q - CntOne;
        end

        timer_inc = timer_q + TimerOne;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StOff;
            en_q      <= 1'b0;
            drained_q <= 1'b0;
            timeout_q <= 1'b0;
            err_q     <= 1'b0;
            w_q       <= '0;
            r_q       <= '0;
            timer_q   <= '0;
        end else if (clr_i) begin
            state_q   <= StOff;
            en_q      <= 1'b0;
            drained_q <= 1'b0;
            timeout_q <= 1'b0;
            err_q     <= 1'b0;
            w_q       <= '0;
            r_q       <= '0;
            timer_q   <= '0;
        end else begin
            w_q       <= w_d;
            r_q       <= r_d;
            drained_q <= 1'b0;
            // en_o follows the registered state, so it lags each transition by one cycle.
            en_q      <= (state_q == StOn);
            if (w_err || r_err) err_q <= 1'b1;

            case (state_q)
                StOff: begin
                    if (en_req_i && (w_q == '0) && (r_q == '0)) state_q <= StOn;
                end
                StOn: begin
                    if (!en_req_i) begin
                        state_q <= StDrain;
                        timer_q <= '0;
                    end
                end
                StDrain: begin
                    if ((w_d == '0) && (r_d == '0)) begin
                        state_q   <= StOff;
                        drained_q <= 1'b1;
                    end else if (compl) begin
                        timer_q <= '0;
                    end else begin
                        timer_q <= timer_inc;
                        if (timer_inc >= TimeoutLim) begin
                            state_q   <= StTimeout;
                            timeout_q <= 1'b1;
                        end
                    end
                end
                StTimeout: begin
                    state_q <= StTimeout;
                end
                default: state_q <= StOff;
            endcase
        end
    end

    assign en_o      = en_q;
    assign state_o   = state_q;
    assign w_outst_o = w_q;
    assign r_outst_o = r_q;
    assign drained_o = drained_q;
    assign timeout_o = timeout_q;
    assign err_o     = err_q;

endmodule
